// File: rtl/game_pkg.sv
// Shared constants and helpers for the battle controller: state codes, opcodes,
// key codes and instruction field access.
package game_pkg;

  localparam logic [7:0] MON_HP_INIT = 8'd100;
  localparam logic [7:0] MON_ATK     = 8'd5;
  localparam logic [7:0] PL_HP_INIT  = 8'd20;
  localparam logic [7:0] PL_ATK_INIT = 8'd10;
  localparam logic [7:0] PL_SIZE     = 8'd16;
  localparam logic [7:0] BOX_X0      = 8'd40;
  localparam logic [7:0] BOX_X1      = 8'd120;
  localparam logic [7:0] BOX_Y0      = 8'd40;
  localparam logic [7:0] BOX_Y1      = 8'd80;
  localparam logic [7:0] STEP        = 8'd2;
  localparam logic [7:0] POS_X_INIT  = 8'd80;
  localparam logic [7:0] POS_Y_INIT  = 8'd60;

  localparam int DODGE_CYCLES = 64;
  localparam int CNT_W        = $clog2(DODGE_CYCLES);

  typedef enum logic [7:0] {
    ST_MENU   = 8'd0,
    ST_ATTACK = 8'd1,
    ST_DODGE  = 8'd2,
    ST_CHECK  = 8'd3,
    ST_WIN    = 8'd4,
    ST_LOSE   = 8'd5
  } state_e;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_MOVE   = 4'd1;
  localparam logic [3:0] OP_DAMAGE = 4'd2;
  localparam logic [3:0] OP_RESET  = 4'd3;

  localparam logic [3:0] KEY_NONE    = 4'd0;
  localparam logic [3:0] KEY_UP      = 4'd1;
  localparam logic [3:0] KEY_RIGHT   = 4'd4;
  localparam logic [3:0] KEY_CONFIRM = 4'd5;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  function automatic logic [3:0] instr_op(input logic [15:0] instr);
    return instr[15:12];
  endfunction

  function automatic logic [1:0] instr_dir(input logic [15:0] instr);
    return instr[1:0];
  endfunction

  function automatic logic [7:0] instr_amt(input logic [15:0] instr);
    return instr[7:0];
  endfunction

  function automatic logic [15:0] make_instr(input logic [3:0] op, input logic [11:0] arg);
    return {op, arg};
  endfunction

  // Subtract with floor at zero.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (b >= a) ? 8'd0 : a - b;
  endfunction

endpackage

// File: rtl/game_player.sv
// Player datapath: holds HP/ATK/size/position and executes one instruction per clock.
module game_player
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  output logic [7:0]  hp,
  output logic [7:0]  atk,
  output logic [7:0]  size,
  output logic [15:0] position,
  output logic        is_death,
  output logic [31:0] p_state
);

  logic [7:0] hp_q, hp_d, atk_q, atk_d, size_q, size_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic [3:0] last_op_q, last_op_d;
  logic [8:0] x_inc, y_inc;

  // Widened so a move near 255 cannot wrap before the clamp.
  assign x_inc = {1'b0, x_q} + {1'b0, STEP};
  assign y_inc = {1'b0, y_q} + {1'b0, STEP};

  always_comb begin
    hp_d      = hp_q;
    atk_d     = atk_q;
    size_d    = size_q;
    x_d       = x_q;
    y_d       = y_q;
    last_op_d = OP_NOP;
    case (instr_op(instr))
      OP_MOVE: begin
        last_op_d = OP_MOVE;
        case (instr_dir(instr))
          DIR_UP:    y_d = (y_q >= BOX_Y0 + STEP) ? y_q - STEP : BOX_Y0;
          DIR_DOWN:  y_d = (y_inc <= {1'b0, BOX_Y1}) ? y_inc[7:0] : BOX_Y1;
          DIR_LEFT:  x_d = (x_q >= BOX_X0 + STEP) ? x_q - STEP : BOX_X0;
          DIR_RIGHT: x_d = (x_inc <= {1'b0, BOX_X1}) ? x_inc[7:0] : BOX_X1;
        endcase
      end
      OP_DAMAGE: begin
        last_op_d = OP_DAMAGE;
        hp_d      = sat_sub(hp_q, instr_amt(instr));
      end
      OP_RESET: begin
        last_op_d = OP_RESET;
        hp_d      = PL_HP_INIT;
        atk_d     = PL_ATK_INIT;
        size_d    = PL_SIZE;
        x_d       = POS_X_INIT;
        y_d       = POS_Y_INIT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_q      <= PL_HP_INIT;
      atk_q     <= PL_ATK_INIT;
      size_q    <= PL_SIZE;
      x_q       <= POS_X_INIT;
      y_q       <= POS_Y_INIT;
      last_op_q <= OP_NOP;
    end else begin
      hp_q      <= hp_d;
      atk_q     <= atk_d;
      size_q    <= size_d;
      x_q       <= x_d;
      y_q       <= y_d;
      last_op_q <= last_op_d;
    end
  end

  assign hp       = hp_q;
  assign atk      = atk_q;
  assign size     = size_q;
  assign position = {x_q, y_q};
  assign is_death = (hp_q == 8'd0);
  assign p_state  = {hp_q, atk_q, size_q, last_op_q, 3'b000, is_death};

endmodule

// File: rtl/game_machine.sv
// Battle controller FSM and monster HP; issues registered instructions to the player.
module game_machine
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  keyboard,
  input  logic        atkPass,
  input  logic [7:0]  dmgMon,
  output logic [7:0]  state,
  output logic [15:0] playerInstruction,
  output logic        isMove,
  output logic [7:0]  monHP,
  output logic        isDeath,
  output logic [31:0] pState,
  output logic [15:0] position,
  output logic [7:0]  size,
  output logic [7:0]  HP,
  output logic [7:0]  ATK
);

  state_e           state_q, state_d;
  logic [7:0]       mon_hp_q, mon_hp_d;
  logic [15:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_move_q;
  logic [3:0]       key_m1;
  logic [7:0]       hp_landing;

  assign key_m1 = keyboard - 4'd1;

  // In CHECK the DAMAGE is still in the instruction register, so decide on the HP it leaves.
  assign hp_landing = (instr_op(instr_q) == OP_DAMAGE) ? sat_sub(HP, instr_amt(instr_q)) : HP;

  always_comb begin
    state_d  = state_q;
    mon_hp_d = mon_hp_q;
    cnt_d    = cnt_q;
    instr_d  = make_instr(OP_NOP, 12'd0);
    case (state_q)
      ST_MENU: begin
        if (keyboard == KEY_CONFIRM) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (atkPass) begin
          mon_hp_d = sat_sub(mon_hp_q, dmgMon);
          cnt_d    = '0;
          state_d  = (mon_hp_d == 8'd0) ? ST_WIN : ST_DODGE;
        end
      end
      ST_DODGE: begin
        if (keyboard >= KEY_UP && keyboard <= KEY_RIGHT)
          instr_d = make_instr(OP_MOVE, {10'd0, key_m1[1:0]});
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DODGE_CYCLES - 1)) begin
          instr_d = make_instr(OP_DAMAGE, {4'd0, MON_ATK});
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = (hp_landing == 8'd0) ? ST_LOSE : ST_MENU;
      end
      ST_WIN, ST_LOSE: ;
      default: state_d = ST_MENU;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_MENU;
      mon_hp_q  <= MON_HP_INIT;
      instr_q   <= make_instr(OP_NOP, 12'd0);
      cnt_q     <= '0;
      is_move_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mon_hp_q  <= mon_hp_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      is_move_q <= (state_d == ST_DODGE);
    end
  end

  game_player u_player (
    .clk      (clk),
    .rst      (reset),
    .instr    (instr_q),
    .hp       (HP),
    .atk      (ATK),
    .size     (size),
    .position (position),
    .is_death (isDeath),
    .p_state  (pState)
  );

  assign state             = state_q;
  assign playerInstruction = instr_q;
  assign isMove            = is_move_q;
  assign monHP             = mon_hp_q;

endmodule

// File: tb/tb_game_machine.sv
// Directed + randomized bench for game_machine, checked against a rule-level model.
module tb_game_machine;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  keyboard;
  logic        atkPass;
  logic [7:0]  dmgMon;
  logic [7:0]  state;
  logic [15:0] playerInstruction;
  logic        isMove;
  logic [7:0]  monHP;
  logic        isDeath;
  logic [31:0] pState;
  logic [15:0] position;
  logic [7:0]  size;
  logic [7:0]  HP;
  logic [7:0]  ATK;

  int errors = 0;
  int checks = 0;

  // Reference model: phase name, monster/player numbers, instruction in flight.
  int m_state, m_mon, m_hp, m_x, m_y, m_cnt, p_op, p_arg, m_last;

  game_machine dut (
    .clk               (clk),
    .reset             (reset),
    .keyboard          (keyboard),
    .atkPass           (atkPass),
    .dmgMon            (dmgMon),
    .state             (state),
    .playerInstruction (playerInstruction),
    .isMove            (isMove),
    .monHP             (monHP),
    .isDeath           (isDeath),
    .pState            (pState),
    .position          (position),
    .size              (size),
    .HP                (HP),
    .ATK               (ATK)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_mon = 100; m_hp = 20; m_x = 80; m_y = 60;
    m_cnt = 0; p_op = 0; p_arg = 0; m_last = 0;
  endtask

  // One clock of game rules: last clock's instruction lands, then the phase logic runs.
  task automatic model_clock(input int key, input int atk, input int dmg);
    m_last = p_op;
    if (p_op == 1) begin
      case (p_arg)
        0: m_y = (m_y - 2 < 40) ? 40 : m_y - 2;
        1: m_y = (m_y + 2 > 80) ? 80 : m_y + 2;
        2: m_x = (m_x - 2 < 40) ? 40 : m_x - 2;
        default: m_x = (m_x + 2 > 120) ? 120 : m_x + 2;
      endcase
    end else if (p_op == 2) begin
      m_hp = (m_hp > p_arg) ? m_hp - p_arg : 0;
    end
    p_op = 0; p_arg = 0;
    case (m_state)
      0: if (key == 5) m_state = 1;
      1: if (atk != 0) begin
           m_mon   = (dmg >= m_mon) ? 0 : m_mon - dmg;
           m_state = (m_mon == 0) ? 4 : 2;
           m_cnt   = 0;
         end
      2: begin
           if (key >= 1 && key <= 4) begin p_op = 1; p_arg = key - 1; end
           m_cnt++;
           if (m_cnt == 64) begin p_op = 2; p_arg = 5; m_state = 3; end
         end
      3: m_state = (m_hp == 0) ? 5 : 0;
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_ps;
    exp_ps = {m_hp[7:0], 8'd10, 8'd16, m_last[3:0], 3'b000, (m_hp == 0)};
    chk({tag, ".state"}, {24'd0, state}, m_state);
    chk({tag, ".monHP"}, {24'd0, monHP}, m_mon);
    chk({tag, ".HP"}, {24'd0, HP}, m_hp);
    chk({tag, ".ATK"}, {24'd0, ATK}, 32'd10);
    chk({tag, ".size"}, {24'd0, size}, 32'd16);
    chk({tag, ".position"}, {16'd0, position}, (m_x << 8) | m_y);
    chk({tag, ".isMove"}, {31'd0, isMove}, (m_state == 2) ? 32'd1 : 32'd0);
    chk({tag, ".isDeath"}, {31'd0, isDeath}, (m_hp == 0) ? 32'd1 : 32'd0);
    chk({tag, ".instr"}, {16'd0, playerInstruction}, (p_op << 12) | p_arg);
    chk({tag, ".pState"}, pState, exp_ps);
  endtask

  task automatic cycle(input logic [3:0] key, input logic atk, input logic [7:0] dmg);
    @(negedge clk);
    keyboard = key; atkPass = atk; dmgMon = dmg;
    model_clock(int'(key), int'(atk), int'(dmg));
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  // Reset is raised between edges so its effect is visible before any clock.
  task automatic do_reset();
    @(negedge clk);
    keyboard = 4'd0; atkPass = 1'b0; dmgMon = 8'd0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [3:0] rand_key();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic dodge_phase();
    repeat (64) cycle(rand_key(), 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic full_round(input logic [7:0] dmg);
    cycle(4'd5, 1'b0, 8'd0);
    cycle(4'd0, 1'b1, dmg);
    dodge_phase();
    cycle(rand_key(), 1'b0, 8'd0);
    $display("round dmg=%0d: state=%0d monHP=%0d HP=%0d pos=%h", dmg, state, monHP, HP, position);
  endtask

  initial begin
    logic [3:0] k;
    reset = 1'b1; keyboard = 4'd0; atkPass = 1'b0; dmgMon = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    chk("por.position", {16'd0, position}, 32'h503C);
    @(negedge clk);
    reset = 1'b0;

    // MENU ignores everything except confirm
    repeat (8) begin
      k = rand_key();
      if (k == 4'd5) k = 4'd0;
      cycle(k, 1'($urandom_range(0, 1)), 8'($urandom));
    end
    chk("menu.idle", {24'd0, state}, 32'd0);
    cycle(4'd5, 1'b0, 8'd0);
    chk("menu.confirm", {24'd0, state}, 32'd1);
    $display("confirm: state=%0d", state);

    repeat (3) cycle(rand_key(), 1'b0, 8'($urandom));
    cycle(4'd0, 1'b1, 8'd10);
    chk("attack.monHP", {24'd0, monHP}, 32'd90);
    chk("attack.state", {24'd0, state}, 32'd2);
    chk("attack.isMove", {31'd0, isMove}, 32'd1);
    $display("attack: monHP=%0d state=%0d", monHP, state);

    repeat (40) cycle(4'd4, 1'b0, 8'd0);
    chk("dodge.x_clamp", {24'd0, position[15:8]}, 32'd120);
    $display("dodge right x40: position=%h", position);
    repeat (24) cycle(rand_key(), 1'b0, 8'd0);
    chk("dodge.to_check", {24'd0, state}, 32'd3);
    cycle(4'd0, 1'b0, 8'd0);
    chk("check.HP", {24'd0, HP}, 32'd15);
    chk("check.menu", {24'd0, state}, 32'd0);
    $display("check: HP=%0d state=%0d", HP, state);

    repeat (3) full_round(8'd1);
    chk("lose.state", {24'd0, state}, 32'd5);
    chk("lose.isDeath", {31'd0, isDeath}, 32'd1);
    repeat (5) cycle(4'd5, 1'b1, 8'd50);
    chk("lose.sticky", {24'd0, state}, 32'd5);

    do_reset();
    full_round(8'd92);
    chk("win.setup_mon", {24'd0, monHP}, 32'd8);
    cycle(4'd5, 1'b0, 8'd0);
    cycle(4'd0, 1'b1, 8'd10);
    chk("win.monHP", {24'd0, monHP}, 32'd0);
    chk("win.state", {24'd0, state}, 32'd4);
    repeat (5) cycle(rand_key(), 1'b1, 8'($urandom));
    chk("win.sticky", {24'd0, state}, 32'd4);
    $display("win: monHP=%0d state=%0d", monHP, state);

    do_reset();
    repeat (2) full_round(8'($urandom_range(0, 40)));

    do_reset();
    cycle(4'd5, 1'b0, 8'd0);
    cycle(4'd0, 1'b1, 8'd3);
    repeat (20) cycle(rand_key(), 1'b0, 8'd0);
    do_reset();
    chk("midreset.state", {24'd0, state}, 32'd0);
    chk("midreset.position", {16'd0, position}, 32'h503C);
    $display("mid-dodge reset: state=%0d position=%h", state, position);
    full_round(8'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
